// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-requester round-robin arbiter in front of the de10_lite_sdram command
// interface. A granted requester owns the controller for one whole transaction:
// command issue, write/read burst, then a turnaround gap. Transactions waiting
// on a controller that never answers are aborted after TimeoutCycles.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i/write_i         per-requester request (held until gnt_o) and direction
//   addr_i/wdata_i        per-requester address and write data, slice k = requester k
//   gnt_o                 one-cycle accept pulse (ISSUE cycle)
//   wdata_ready_o         write beat consumed this cycle
//   rdata_o/rvalid_o      read beats forwarded to the owner
//   done_o/err_o          end-of-transaction / timeout pulses
//   busy_o                arbiter not idle
//   sdram_*               controller command interface
module sdram_arbiter #(
    parameter int BurstLength      = 8,
    parameter int WriteBurst       = 1,
    parameter int AddrWidth        = 25,
    parameter int DataWidth        = 16,
    parameter int TurnaroundCycles = 2,
    parameter int TimeoutCycles    = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             req_i,
    input  logic [1:0]             write_i,
    input  logic [2*AddrWidth-1:0] addr_i,
    input  logic [2*DataWidth-1:0] wdata_i,
    output logic [1:0]             gnt_o,
    output logic [1:0]             wdata_ready_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [1:0]             rvalid_o,
    output logic [1:0]             done_o,
    output logic [1:0]             err_o,
    output logic                   busy_o,
    output logic [1:0]             sdram_command_o,
    output logic [AddrWidth-1:0]   sdram_address_o,
    output logic [DataWidth-1:0]   sdram_wdata_o,
    input  logic [DataWidth-1:0]   sdram_rdata_i,
    input  logic                   sdram_rvalid_i,
    input  logic                   sdram_wdone_i
);
    localparam int BW        = $clog2(BurstLength + 1);
    localparam int TW        = $clog2(TimeoutCycles + 1);
    // A zero turnaround still spends one cycle in GAP so done_o has a home.
    localparam int GAP_LEN   = (TurnaroundCycles == 0) ? 1 : TurnaroundCycles;
    localparam int GW        = $clog2(GAP_LEN + 1);
    localparam bit WR_SINGLE = (WriteBurst == 0) || (BurstLength == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WR_WAIT, S_WR_BURST, S_RD_WAIT, S_RD_BURST, S_GAP
    } state_t;

    state_t               r_state;
    logic                 r_owner;   // 0/1 = requester owning the controller
    logic                 r_ptr;     // requester favoured when both request
    logic                 r_write;
    logic [AddrWidth-1:0] r_addr;
    logic [BW-1:0]        r_beat;
    logic [TW-1:0]        r_tmo;
    logic [GW-1:0]        r_gap;
    logic                 r_done;
    logic                 r_err;

    logic                 w_sel;
    logic [1:0]           w_owner_oh;
    logic                 w_wbeat;
    logic                 w_rd_fwd;
    logic [DataWidth-1:0] w_owner_wdata;

    // Contention goes to the pointer; otherwise whoever is requesting.
    assign w_sel         = (req_i == 2'b11) ? r_ptr : req_i[1];
    assign w_owner_oh    = r_owner ? 2'b10 : 2'b01;
    assign w_owner_wdata = r_owner ? wdata_i[2*DataWidth-1:DataWidth] : wdata_i[DataWidth-1:0];
    // Beat 0 goes out with the write command, the rest after wdone.
    assign w_wbeat       = (r_state == S_ISSUE && r_write) || (r_state == S_WR_BURST);
    // Read beats pass straight through; beats outside a read are dropped.
    assign w_rd_fwd      = sdram_rvalid_i && (r_state == S_RD_WAIT || r_state == S_RD_BURST);

    assign gnt_o           = (r_state == S_ISSUE) ? w_owner_oh : 2'b00;
    assign wdata_ready_o   = w_wbeat ? w_owner_oh : 2'b00;
    assign sdram_wdata_o   = w_wbeat ? w_owner_wdata : '0;
    assign rvalid_o        = w_rd_fwd ? w_owner_oh : 2'b00;
    assign rdata_o         = w_rd_fwd ? sdram_rdata_i : '0;
    assign done_o          = r_done ? w_owner_oh : 2'b00;
    assign err_o           = r_err ? w_owner_oh : 2'b00;
    assign busy_o          = (r_state != S_IDLE);
    assign sdram_command_o = (r_state != S_ISSUE) ? 2'd0 : (r_write ? 2'd1 : 2'd2);
    assign sdram_address_o = r_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_beat  <= '0;
            r_tmo   <= '0;
            r_gap   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req_i) begin
                        r_owner <= w_sel;
                        r_ptr   <= ~w_sel;
                        r_write <= write_i[w_sel];
                        r_addr  <= w_sel ? addr_i[2*AddrWidth-1:AddrWidth] : addr_i[AddrWidth-1:0];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmo   <= '0;
                    r_beat  <= '0;
                    r_state <= r_write ? S_WR_WAIT : S_RD_WAIT;
                end
                S_WR_WAIT: begin
                    if (sdram_wdone_i) begin
                        if (WR_SINGLE) begin
                            r_done  <= 1'b1;
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_WR_BURST;
                        end
                    end else if (int'(r_tmo) == TimeoutCycles - 1) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WR_BURST: begin
                    // Beats 1..BurstLength-1, one per cycle.
                    if (int'(r_beat) == BurstLength - 2) begin
                        r_done  <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (sdram_rvalid_i) begin
                        r_beat <= BW'(1);
                        if (BurstLength == 1) begin
                            r_done  <= 1'b1;
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_RD_BURST;
                        end
                    end else if (int'(r_tmo) == TimeoutCycles - 1) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_gap   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RD_BURST: begin
                    // r_beat counts beats already received; no timeout once started.
                    if (sdram_rvalid_i) begin
                        if (int'(r_beat) == BurstLength - 1) begin
                            r_done  <= 1'b1;
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (int'(r_gap) == GAP_LEN - 1) r_state <= S_IDLE;
                    else                            r_gap   <= r_gap + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a behavioural SDRAM stub, a negedge monitor with
// write/read scoreboards, a table of arbitration vectors and hand sequences
// for round-robin streaming, timeout, mid-burst reset and single-beat writes.
module tb_sdram_arbiter;
    localparam int BL = 8, TURN = 2, TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  req = 2'b00, wr = 2'b00;
    logic [24:0] a  [2];
    logic [15:0] wd [2];
    logic [49:0] addr;
    logic [31:0] wdata;
    assign addr  = {a[1], a[0]};
    assign wdata = {wd[1], wd[0]};

    logic [1:0]  gnt, wrdy, rvalid, done, err, cmd;
    logic [15:0] rdata, swdata;
    logic [24:0] saddr;
    logic        busy;
    logic [15:0] srdata = 16'h0;
    logic        srvalid = 1'b0, swdone = 1'b0;

    sdram_arbiter #(.BurstLength(BL), .WriteBurst(1), .AddrWidth(25), .DataWidth(16),
                    .TurnaroundCycles(TURN), .TimeoutCycles(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(wr), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .wdata_ready_o(wrdy), .rdata_o(rdata), .rvalid_o(rvalid), .done_o(done),
        .err_o(err), .busy_o(busy), .sdram_command_o(cmd), .sdram_address_o(saddr),
        .sdram_wdata_o(swdata), .sdram_rdata_i(srdata), .sdram_rvalid_i(srvalid),
        .sdram_wdone_i(swdone));

    // Second instance: single-beat writes.
    logic [1:0]  s_req = 2'b00, s_wr = 2'b01;
    logic [49:0] s_addr = 50'h42;
    logic [31:0] s_wdata = 32'h0000_5A5A;
    logic [1:0]  s_gnt, s_wrdy, s_rvalid, s_done, s_err, s_cmd;
    logic [15:0] s_rdata, s_swdata;
    logic [15:0] s_srdata = 16'h0;
    logic [24:0] s_saddr;
    logic        s_busy, s_srvalid = 1'b0, s_wdone = 1'b0;

    sdram_arbiter #(.BurstLength(BL), .WriteBurst(0), .AddrWidth(25), .DataWidth(16),
                    .TurnaroundCycles(TURN), .TimeoutCycles(64)) dut_s (
        .clk_i(clk), .rst_i(rst), .req_i(s_req), .write_i(s_wr), .addr_i(s_addr), .wdata_i(s_wdata),
        .gnt_o(s_gnt), .wdata_ready_o(s_wrdy), .rdata_o(s_rdata), .rvalid_o(s_rvalid),
        .done_o(s_done), .err_o(s_err), .busy_o(s_busy), .sdram_command_o(s_cmd),
        .sdram_address_o(s_saddr), .sdram_wdata_o(s_swdata), .sdram_rdata_i(s_srdata),
        .sdram_rvalid_i(s_srvalid), .sdram_wdone_i(s_wdone));

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    logic [15:0] mem [int];      // what the controller stub received
    logic [15:0] ref_mem [int];  // what the bench intended to write
    function automatic logic [15:0] mem_rd(input int k);
        return mem.exists(k) ? mem[k] : 16'h0;
    endfunction
    function automatic logic [15:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : 16'h0;
    endfunction

    // Controller stub: wdone 3 cycles after a write command, BL read beats
    // starting 3 cycles after a read command.
    int          wph = 0, rph = 0;
    logic [24:0] raddr = '0;
    logic        no_wdone = 1'b0;
    always @(posedge clk) begin
        swdone  <= 1'b0;
        srvalid <= 1'b0;
        if (wph != 0) begin
            wph    <= (wph == 3) ? 0 : wph + 1;
            swdone <= (wph == 3) && !no_wdone;
        end
        if (rph != 0) begin
            if (rph >= 3) begin
                srvalid <= 1'b1;
                srdata  <= mem_rd(int'(raddr) + rph - 3);
            end
            rph <= (rph == BL + 2) ? 0 : rph + 1;
        end
        if (cmd == 2'd1) wph <= 1;
        if (cmd == 2'd2) begin
            rph   <= 1;
            raddr <= saddr;
        end
    end

    // Monitor and scoreboards.
    logic [15:0] wq [$];
    logic [15:0] rq [$];
    int          cyc = 0, last_iss = -100, rown = 0, rbeats = 0, wbeat = 0, mk = 0, s_nready = 0;
    logic [24:0] waddr = '0;
    initial begin : mon
        forever begin
            @(negedge clk);
            cyc++;
            if (gnt != 2'b00) begin
                mk = gnt[1] ? 1 : 0;
                if (wr[mk]) begin
                    for (int i = 0; i < BL; i++) begin
                        wq.push_back(wd[mk] + 16'(i));
                        ref_mem[int'(a[mk]) + i] = wd[mk] + 16'(i);
                    end
                end else begin
                    rown = mk;
                    for (int i = 0; i < BL; i++) rq.push_back(ref_rd(int'(a[mk]) + i));
                end
            end
            if (cmd != 2'd0) begin
                chk("iss_spacing", 128'(cyc - last_iss - 1 >= TURN), 128'd1);
                chk("iss_cmd", cmd, wr[mk] ? 2'd1 : 2'd2);
                chk("iss_addr", saddr, a[mk]);
                last_iss = cyc;
                waddr    = saddr;
                wbeat    = 0;
            end
            if (wrdy != 2'b00) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wdata: unexpected beat %h", swdata);
                end else chk("wdata", swdata, wq.pop_front());
                mem[int'(waddr) + wbeat] = swdata;
                wbeat++;
                wd[wrdy[1]] = wd[wrdy[1]] + 16'd1;
            end
            if (rvalid != 2'b00) begin
                chk("rv_owner", rvalid, (rown == 1) ? 2'b10 : 2'b01);
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rdata: unexpected beat %h", rdata);
                end else chk("rdata", rdata, rq.pop_front());
                rbeats++;
            end
            if (done != 2'b00) begin
                if (err == 2'b00) chk("q_drained", 128'(wq.size() + rq.size()), 128'd0);
                else wq.delete();
            end
            if (s_wrdy != 2'b00) begin
                s_nready++;
                chk("sb_wdata", s_swdata, 16'h5A5A);
            end
        end
    end

    task automatic wait_gnt(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin g = gnt; return; end
        end
    endtask
    task automatic wait_done(output logic [1:0] d, output logic [1:0] e, output int n);
        d = 2'b00; e = 2'b00; n = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin d = done; e = err; n = i; return; end
        end
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle", busy, 1'b0);
    endtask

    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [1:0]  exp;
        logic [24:0] a0;
        logic [24:0] a1;
    } vec_t;
    vec_t tv [6];

    logic [1:0] g, d, e;
    int         n, r0;
    initial begin : main
        a[0] = '0; a[1] = '0;
        wd[0] = 16'hA000; wd[1] = 16'hB000;
        tv[0] = '{2'b01, 2'b01, 2'b01, 25'h123, 25'h0};    // write 0 -> A000..A007
        tv[1] = '{2'b10, 2'b00, 2'b10, 25'h0,   25'h123};  // read back via 1
        tv[2] = '{2'b11, 2'b11, 2'b01, 25'h200, 25'h300};  // contention, pointer at 0
        tv[3] = '{2'b11, 2'b01, 2'b10, 25'h200, 25'h200};  // contention, pointer at 1
        tv[4] = '{2'b10, 2'b10, 2'b10, 25'h0,   25'h400};  // lone 1 write B000..
        tv[5] = '{2'b11, 2'b00, 2'b01, 25'h400, 25'h123};  // contention, pointer at 0

        repeat (3) @(negedge clk);
        chk("rst_state_a", {gnt, wrdy, rdata, rvalid, done, err, busy, cmd}, 128'd0);
        chk("rst_state_b", {saddr, swdata}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tv[i]) begin
            a[0] = tv[i].a0; a[1] = tv[i].a1; wr = tv[i].wr; req = tv[i].req;
            wait_gnt(g);
            chk("tbl_gnt", g, tv[i].exp);
            req = 2'b00;
            wait_done(d, e, n);
            chk("tbl_done", {d, e}, {tv[i].exp, 2'b00});
            wait_idle();
        end

        // Both hold requests: grants alternate, starting with 1 (pointer at 1).
        a[0] = 25'h500; a[1] = 25'h123; wr = 2'b01; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g);
            chk("rr_gnt", g, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k == 3) req = 2'b00;
        end
        wait_idle();

        // Controller never signals wdone.
        no_wdone = 1'b1;
        a[0] = 25'h600; wr = 2'b01; req = 2'b01;
        wait_gnt(g);
        chk("tmo_gnt", g, 2'b01);
        req = 2'b00;
        wait_done(d, e, n);
        chk("tmo_cycles", 128'(n), 128'd17);
        chk("tmo_flags", {d, e}, {2'b01, 2'b01});
        no_wdone = 1'b0;
        wait_idle();
        a[1] = 25'h123; wr = 2'b00; req = 2'b10;
        wait_gnt(g);
        chk("post_tmo_gnt", g, 2'b10);
        req = 2'b00;
        wait_done(d, e, n);
        chk("post_tmo_done", {d, e}, {2'b10, 2'b00});
        wait_idle();

        // Reset in the middle of a read burst owned by requester 0.
        a[0] = 25'h123; wr = 2'b00; req = 2'b01;
        wait_gnt(g);
        chk("rstb_gnt", g, 2'b01);
        req = 2'b00;
        r0 = rbeats;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (rbeats - r0 >= 4) break;
        end
        chk("rstb_beats", 128'(rbeats - r0), 128'd4);
        rst = 1'b1;
        #1;
        chk("rstb_outs_a", {gnt, wrdy, rdata, rvalid, done, err, busy, cmd}, 128'd0);
        chk("rstb_outs_b", {saddr, swdata}, 128'd0);
        rq.delete();
        repeat (6) @(negedge clk);
        rst = 1'b0;
        // Pointer must be back at requester 0.
        a[0] = 25'h700; a[1] = 25'h710; wr = 2'b11; req = 2'b11;
        wait_gnt(g);
        chk("post_rst_gnt", g, 2'b01);
        req = 2'b00;
        wait_done(d, e, n);
        chk("post_rst_done", {d, e}, {2'b01, 2'b00});
        wait_idle();

        // Single-beat write instance.
        s_req = 2'b01;
        g = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_gnt != 2'b00) begin g = s_gnt; break; end
        end
        chk("sb_gnt", g, 2'b01);
        s_req = 2'b00;
        repeat (2) @(negedge clk);
        chk("sb_no_early_done", s_done, 2'b00);
        s_wdone = 1'b1;
        d = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_wdone = 1'b0;
            if (s_done != 2'b00) begin d = s_done; break; end
        end
        chk("sb_done", d, 2'b01);
        repeat (6) @(negedge clk);
        chk("sb_ready_cnt", 128'(s_nready), 128'd1);
        chk("sb_idle", s_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
